// File: rtl/blitreg_dec.sv
// rtl/blitreg_dec.sv - GPU register-window decoder with deferred protected writes
module blitreg_dec #(
  parameter int              AW        = 6,
  parameter int              NREG      = 48,
  parameter int              PROT_BASE = 16,
  parameter int              DW        = 32,
  parameter logic [NREG-1:0] RDMASK    = {NREG{1'b1}}
) (
  input  logic            sys_clk,
  input  logic            resetl,
  input  logic [23:0]     gpu_addr,
  input  logic [DW-1:0]   gpu_din,
  input  logic            gpu_memw,
  input  logic            bliten,
  input  logic            blit_back,
  input  logic [NREG-1:0] ldi,
  output logic [NREG-1:0] ld,
  output logic [DW-1:0]   ld_data,
  output logic [NREG-1:0] rd,
  output logic            gpu_wait,
  output logic            ovf,
  input  logic            ovf_clr
);

  typedef enum logic {IDLE, HOLD} state_t;

  localparam logic [AW:0]     NREG_W = (AW+1)'(NREG);
  localparam logic [AW:0]     PROT_W = (AW+1)'(PROT_BASE);
  localparam logic [NREG-1:0] ONE    = NREG'(1);

  state_t          state;
  logic [NREG-1:0] ld_r;
  logic [AW-1:0]   pend_idx;
  logic [DW-1:0]   pend_data;

  logic [AW-1:0] idx;
  logic          in_range;
  logic          prot;
  logic          wr_req;
  logic          rd_req;

  assign idx      = gpu_addr[AW+1:2];
  assign in_range = {1'b0, idx} < NREG_W;
  assign prot     = {1'b0, idx} >= PROT_W;
  assign wr_req   = bliten & gpu_memw & in_range;
  assign rd_req   = bliten & ~gpu_memw & in_range & RDMASK[idx];

  wire unused_addr = &{1'b0, gpu_addr[23:AW+2], gpu_addr[1:0]};

  assign ld = ld_r | ldi;

  always_ff @(posedge sys_clk) begin
    if (!resetl) begin
      state     <= IDLE;
      ld_r      <= '0;
      ld_data   <= '0;
      rd        <= '0;
      gpu_wait  <= 1'b0;
      ovf       <= 1'b0;
      pend_idx  <= '0;
      pend_data <= '0;
    end else begin
      ld_r <= '0;
      rd   <= '0;
      // set after clear so a simultaneous drop keeps ovf high
      if (ovf_clr)
        ovf <= 1'b0;
      if (wr_req && gpu_wait)
        ovf <= 1'b1;

      case (state)
        IDLE: begin
          if (wr_req && prot && blit_back) begin
            pend_idx  <= idx;
            pend_data <= gpu_din;
            gpu_wait  <= 1'b1;
            state     <= HOLD;
          end else if (wr_req) begin
            ld_r    <= ONE << idx;
            ld_data <= gpu_din;
          end
        end
        HOLD: begin
          if (!blit_back) begin
            ld_r      <= ONE << pend_idx;
            ld_data   <= pend_data;
            gpu_wait  <= 1'b0;
            pend_idx  <= '0;
            pend_data <= '0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      if (rd_req)
        rd <= ONE << idx;
    end
  end

endmodule

// File: tb/tb_blitreg_dec.sv
// tb/tb_blitreg_dec.sv - randomized self-checking bench for blitreg_dec
module tb_blitreg_dec;

  localparam int          NREG = 48;
  localparam logic [47:0] RDM  = ~((48'h1 << 8) | (48'h1 << 30));

  logic        sys_clk = 1'b0;
  logic        resetl;
  logic [23:0] gpu_addr;
  logic [31:0] gpu_din;
  logic        gpu_memw;
  logic        bliten;
  logic        blit_back;
  logic [47:0] ldi;
  logic [47:0] ld;
  logic [31:0] ld_data;
  logic [47:0] rd;
  logic        gpu_wait;
  logic        ovf;
  logic        ovf_clr;

  blitreg_dec #(.AW(6), .NREG(NREG), .PROT_BASE(16), .DW(32), .RDMASK(RDM)) dut (
    .sys_clk(sys_clk), .resetl(resetl), .gpu_addr(gpu_addr), .gpu_din(gpu_din),
    .gpu_memw(gpu_memw), .bliten(bliten), .blit_back(blit_back), .ldi(ldi),
    .ld(ld), .ld_data(ld_data), .rd(rd), .gpu_wait(gpu_wait), .ovf(ovf),
    .ovf_clr(ovf_clr)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    int          idx;
    logic [31:0] data;
  } pend_t;

  pend_t       pend_q[$];
  logic [47:0] m_ld_r;
  logic [31:0] m_ld_data;
  logic [47:0] m_rd;
  logic        m_ovf;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
  endtask

  task automatic drive(input bit be, input bit w, input int idx, input logic [31:0] d, input bit bb);
    bliten    = be;
    gpu_memw  = w;
    gpu_addr  = {16'($urandom), 6'(idx), 2'($urandom)};
    gpu_din   = d;
    blit_back = bb;
  endtask

  // Reference: one-entry queue of deferred writes; waiting means the queue is non-empty
  task automatic model_edge();
    int  a;
    bit  waiting;
    bit  wr;
    a       = int'(gpu_addr[7:2]);
    waiting = pend_q.size() != 0;
    wr      = bliten && gpu_memw && a < NREG;
    if (!resetl) begin
      pend_q.delete();
      m_ld_r = '0; m_ld_data = '0; m_rd = '0; m_ovf = 1'b0;
      return;
    end
    m_ld_r = '0;
    m_rd   = '0;
    if (ovf_clr) m_ovf = 1'b0;
    if (wr) begin
      if (waiting) m_ovf = 1'b1;
      else if (a >= 16 && blit_back) pend_q.push_back('{idx: a, data: gpu_din});
      else begin
        m_ld_r    = 48'h1 << a;
        m_ld_data = gpu_din;
      end
    end
    if (waiting && !blit_back) begin
      m_ld_r    = 48'h1 << pend_q[0].idx;
      m_ld_data = pend_q[0].data;
      void'(pend_q.pop_front());
    end
    if (bliten && !gpu_memw && a < NREG && RDM[a]) m_rd = 48'h1 << a;
  endtask

  task automatic cycle();
    @(posedge sys_clk);
    model_edge();
    #1;
    check("ld", 64'(ld), 64'(m_ld_r | ldi));
    check("ld_data", 64'(ld_data), 64'(m_ld_data));
    check("rd", 64'(rd), 64'(m_rd));
    check("gpu_wait", 64'(gpu_wait), 64'(pend_q.size() != 0));
    check("ovf", 64'(ovf), 64'(m_ovf));
  endtask

  initial begin
    m_ld_r = '0; m_ld_data = '0; m_rd = '0; m_ovf = 1'b0;
    resetl = 1'b0; ovf_clr = 1'b0; ldi = '0;
    drive(0, 0, 0, 32'h0, 0);
    cycle(); cycle();
    check("reset_ld", 64'(ld), 64'h0);
    check("reset_wait", 64'(gpu_wait), 64'h0);
    resetl = 1'b1;

    drive(1, 1, 3, 32'h12345678, 0); cycle();
    check("direct_ld", 64'(ld), 64'h8);
    check("direct_data", 64'(ld_data), 64'h12345678);
    drive(0, 0, 0, 32'h0, 0); cycle();
    check("direct_ld_once", 64'(ld), 64'h0);

    drive(1, 1, 20, 32'hCAFEF00D, 1); cycle();
    check("defer_wait", 64'(gpu_wait), 64'h1);
    drive(0, 0, 0, 32'h0, 1);
    for (int i = 0; i < 4; i++) cycle();
    drive(0, 0, 0, 32'h0, 0); cycle();
    check("defer_issue_ld", 64'(ld), 64'h1 << 20);
    check("defer_issue_data", 64'(ld_data), 64'hCAFEF00D);
    check("defer_issue_wait", 64'(gpu_wait), 64'h0);
    cycle();

    drive(1, 1, 21, 32'h11112222, 1); cycle();
    drive(1, 1, 5, 32'h55555555, 1); cycle();
    check("ovf_set", 64'(ovf), 64'h1);
    drive(0, 0, 0, 32'h0, 1); ovf_clr = 1'b1; cycle();
    check("ovf_clr", 64'(ovf), 64'h0);
    drive(1, 1, 6, 32'h66666666, 1); cycle();
    check("ovf_set_wins", 64'(ovf), 64'h1);
    ovf_clr = 1'b0;
    drive(0, 0, 0, 32'h0, 0); cycle(); cycle();
    ovf_clr = 1'b1; cycle(); ovf_clr = 1'b0;

    drive(1, 0, 7, 32'h0, 0); cycle();
    check("rd7", 64'(rd), 64'h80);
    drive(1, 0, 8, 32'h0, 0); cycle();
    check("rd8_masked", 64'(rd), 64'h0);
    drive(1, 0, 60, 32'h0, 0); cycle();
    drive(1, 1, 60, 32'h0, 0); cycle();
    check("oor_ld", 64'(ld), 64'h0);
    check("oor_ovf", 64'(ovf), 64'h0);

    drive(1, 1, 30, 32'hDEADBEEF, 1); cycle();
    drive(0, 0, 0, 32'h0, 1); resetl = 1'b0; cycle();
    resetl = 1'b1; drive(0, 0, 0, 32'h0, 0);
    for (int i = 0; i < 3; i++) cycle();
    check("rst_discard_wait", 64'(gpu_wait), 64'h0);

    ldi = 48'h4;
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 2, 32'hA5A50000 + 32'(i), 0); cycle();
      check("ldi_and_ld_data", 64'(ld_data), 64'hA5A50000 + 64'(i));
    end
    ldi = '0;

    drive(1, 1, 40, 32'h40404040, 1); cycle();
    drive(0, 0, 0, 32'h0, 0); cycle();
    check("late_drop_issue", 64'(ld), 64'h1 << 40);
    cycle();

    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 9) < 7, $urandom_range(0, 1) == 1,
            int'($urandom_range(0, 63)), $urandom,
            ($urandom_range(0, 9) < 6) ? blit_back : bit'($urandom_range(0, 1)));
      ovf_clr = $urandom_range(0, 9) == 0;
      resetl  = $urandom_range(0, 199) != 0;
      ldi     = ($urandom_range(0, 3) == 0) ? (48'h1 << $urandom_range(0, 47)) : 48'h0;
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/blitreg_dec.md
Name: blitreg_dec

Overview:
Parametrised, registered register-file decoder for the blitter's GPU-side register window. It generalises the fixed 5×8 write decode to NREG registers and adds registered read strobes. Writes to protected registers made while the blitter is running are captured in a one-entry holding buffer, and the GPU is stalled until the write is issued. It sits between the GPU local bus and the blitter register file, and ORs in blitter-internal load requests.

Parameters:
AW, 6, word-index bits; index = gpu_addr[AW+1:2]
NREG, 48, number of registers decoded (NREG ≤ 2^AW)
PROT_BASE, 16, indices ≥ PROT_BASE are protected while blit_back=1
DW, 32, write data width
RDMASK, {NREG{1'b1}}, bit i=1 means register i has a read strobe

Ports:
sys_clk  in  1  system clock, all state on rising edge
resetl  in  1  synchronous active-low reset
gpu_addr  in  24  GPU byte address; bits [AW+1:2] used
gpu_din  in  DW  GPU write data
gpu_memw  in  1  1=write, 0=read
bliten  in  1  blitter register window selected this cycle
blit_back  in  1  blitter active; protected writes deferred
ldi  in  NREG  blitter-internal load requests, unregistered
ld  out  NREG  register load strobes = ld_r | ldi
ld_data  out  DW  data accompanying ld_r
rd  out  NREG  registered read strobes
gpu_wait  out  1  GPU stall, registered
ovf  out  1  sticky: write dropped while gpu_wait=1
ovf_clr  in  1  clears ovf

Behaviour:
- Reset (resetl=0 at an edge): ld_r=0, ld_data=0, rd=0, gpu_wait=0, ovf=0, pending buffer empty. Applies mid-deferral: a pending write is discarded and never issued.
- idx = gpu_addr[AW+1:2]. A request is in range when idx < NREG. Out-of-range accesses produce no strobe, no wait and no ovf.
- Direct write: conditions are bliten & gpu_memw & in-range & !gpu_wait & (idx < PROT_BASE | !blit_back).
  - Next edge: ld_r = one-hot(idx), ld_data = gpu_din.
  - Latency 1 cycle; ld_r lasts exactly one cycle.
- Deferred write: conditions are bliten & gpu_memw & in-range & !gpu_wait & idx ≥ PROT_BASE & blit_back.
  - Next edge: pend_idx=idx, pend_data=gpu_din, gpu_wait=1. No strobe.
- States: IDLE → (deferred write) → HOLD → (blit_back=0 sampled) → IDLE.
  - In HOLD, on the first edge where blit_back=0: ld_r = one-hot(pend_idx), ld_data = pend_data, gpu_wait=0, buffer cleared. All of these happen on the same edge.
- Any write with bliten & gpu_memw while gpu_wait=1 is ignored and sets ovf=1 on the next edge. ovf holds until ovf_clr=1. If set and clear occur in the same cycle, set wins.
- Read: bliten & !gpu_memw & in-range & RDMASK[idx] gives rd = one-hot(idx) at the next edge, for 1 cycle. Reads are never deferred and are honoured while gpu_wait=1.
- ld = ld_r | ldi, bitwise and combinational. An ldi bit and ld_r may coincide; the register file takes ld_data only for ld_r bits and its own internal data for ldi bits.
- ld_data holds its last value when ld_r=0.
- blit_back may drop in the same cycle the deferral is captured. HOLD is still entered, and the issue happens on the following edge: 2 cycles after the request, with gpu_wait high for exactly 1 cycle.
- At most one bit of ld_r and of rd is set in any cycle.

Test Plan:
- Reset then write idx 3, data 0x12345678, blit_back=0 → cycle+1: ld=0x8, ld_data=0x12345678; cycle+2: ld=0.
- Write idx 20, data 0xCAFEF00D, blit_back=1 for 5 more cycles → gpu_wait=1 from cycle+1; ld=0 throughout; on the edge after blit_back falls, ld bit20=1 with ld_data 0xCAFEF00D and gpu_wait=0 on the same edge.
- While gpu_wait=1, write idx 5 → no ld bit5, ovf=1; ovf_clr pulse → ovf=0; ovf_clr and a dropped write in the same cycle → ovf stays 1.
- Read idx 7 with RDMASK bit7=1, then idx 8 with bit8=0, then idx 60 (out of range, NREG=48) → rd bit7 one cycle, then no rd, then no rd and no ovf.
- Deferred write pending, resetl=0 for one cycle, then blit_back=0 → gpu_wait=0, no ld strobe ever issued.
- ldi bit 2 held high with a simultaneous direct write to idx 2 → ld bit2 high each cycle and ld_data equal to the write data.
